// File: rtl/pc_pkg.sv
// Shared types and defaults for the MIPS program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SRC_SEQ    = 3'd0,
    SRC_BRANCH = 3'd1,
    SRC_JUMP   = 3'd2,
    SRC_JR     = 3'd3,
    SRC_ERET   = 3'd4
  } src_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select (eret > jr > jump > branch > pc+4) with
// misalignment detection on redirect targets.
module pc_next_mux
  import pc_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] epc,
  input  logic        eret,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output src_t        src,
  output logic        redirect,
  output logic        misaligned
);

  // Priority chain; the sequential path can never be misaligned.
  always_comb begin
    next_pc = pc_plus4;
    src     = SRC_SEQ;
    if (eret) begin
      next_pc = epc;
      src     = SRC_ERET;
    end else if (jr) begin
      next_pc = jr_target;
      src     = SRC_JR;
    end else if (jump) begin
      next_pc = jump_target;
      src     = SRC_JUMP;
    end else if (branch_taken) begin
      next_pc = branch_target;
      src     = SRC_BRANCH;
    end else begin
      next_pc = pc_plus4;
      src     = SRC_SEQ;
    end
    redirect   = (src != SRC_SEQ);
    misaligned = redirect && is_misaligned(next_pc);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: BOOT/FETCH/FLUSH sequencing, PC/EPC registers.
// Optional delayed-branch behaviour is enabled by defining BRANCH_DELAY_SLOT_EN.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        fetch_req,
  input  logic        fetch_ack,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        addr_err,
  output logic        in_flush
);

  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc_next;
  logic [31:0] epc_next;
  logic [31:0] exc_epc;
  logic        addr_err_next;
  logic [1:0]  flush_cnt;
  logic [1:0]  flush_cnt_next;
  logic        advance;
  logic [31:0] mux_pc;
  src_t        mux_src;
  logic        mux_redirect;
  logic        mux_misaligned;

`ifdef BRANCH_DELAY_SLOT_EN
  logic        pend_valid;
  logic        pend_valid_next;
  logic [31:0] pend_target;
  logic [31:0] pend_target_next;
  // In the delay slot the faulting instruction is reported as the branch itself.
  assign exc_epc = pend_valid ? (pc - 32'd4) : pc;
`else
  assign exc_epc = pc;
`endif

  assign advance  = fetch_ack & ~stall;
  assign pc_plus4 = pc + 32'd4;

  pc_next_mux u_next_mux (
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .eret          (eret),
    .jr            (jr),
    .jr_target     (jr_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (mux_pc),
    .src           (mux_src),
    .redirect      (mux_redirect),
    .misaligned    (mux_misaligned)
  );

  // Next-state, next-PC and exception entry.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    epc_next       = epc;
    addr_err_next  = 1'b0;
    flush_cnt_next = flush_cnt;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
`endif
    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (exc_req) begin
          epc_next       = exc_epc;
          pc_next        = EXC_VECTOR;
          state_next     = ST_FLUSH;
          flush_cnt_next = 2'd0;
`ifdef BRANCH_DELAY_SLOT_EN
          pend_valid_next = 1'b0;
`endif
        end else if (advance) begin
`ifdef BRANCH_DELAY_SLOT_EN
          if (pend_valid) begin
            pc_next         = pend_target;
            pend_valid_next = 1'b0;
          end else if (mux_misaligned) begin
            epc_next       = pc;
            pc_next        = EXC_VECTOR;
            addr_err_next  = 1'b1;
            state_next     = ST_FLUSH;
            flush_cnt_next = 2'd0;
          end else if (mux_redirect) begin
            pend_valid_next  = 1'b1;
            pend_target_next = mux_pc;
            pc_next          = pc_plus4;
          end else begin
            pc_next = pc_plus4;
          end
`else
          if (mux_misaligned) begin
            epc_next       = pc;
            pc_next        = EXC_VECTOR;
            addr_err_next  = 1'b1;
            state_next     = ST_FLUSH;
            flush_cnt_next = 2'd0;
          end else begin
            pc_next = mux_pc;
          end
`endif
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_next     = ST_FETCH;
          flush_cnt_next = 2'd0;
        end else begin
          flush_cnt_next = flush_cnt + 2'd1;
        end
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // State and architectural registers; fetch_req/in_flush registered from next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_BOOT;
      pc        <= RESET_VECTOR;
      epc       <= 32'h0000_0000;
      addr_err  <= 1'b0;
      flush_cnt <= 2'd0;
      fetch_req <= 1'b0;
      in_flush  <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= 1'b0;
      pend_target <= 32'h0000_0000;
`endif
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      epc       <= epc_next;
      addr_err  <= addr_err_next;
      flush_cnt <= flush_cnt_next;
      fetch_req <= (state_next == ST_FETCH);
      in_flush  <= (state_next == ST_FLUSH);
`ifdef BRANCH_DELAY_SLOT_EN
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
`endif
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table, randomized run against
// a reference model, and a delayed-branch sequence when BRANCH_DELAY_SLOT_EN is set.
module tb_pc_sequencer;

  localparam logic [31:0] EXC_V   = 32'h8000_0180;
  localparam int          FLUSH_N = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ack, branch_taken, jump, jr, exc_req, eret;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        fetch_req, addr_err, in_flush;
  logic [31:0] pc, pc_plus4, epc;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (EXC_V),
    .FLUSH_CYCLES (FLUSH_N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .fetch_req     (fetch_req),
    .fetch_ack     (fetch_ack),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .exc_req       (exc_req),
    .eret          (eret),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .epc           (epc),
    .addr_err      (addr_err),
    .in_flush      (in_flush)
  );

  int errors = 0;
  int checks = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of boot/flush cycles plus architectural PC/EPC.
  bit          m_booted;
  int          m_flush_left;
  logic [31:0] m_pc, m_epc;
  bit          m_aerr;

  task automatic model_reset();
    m_booted     = 1'b0;
    m_flush_left = 0;
    m_pc         = 32'h0000_0000;
    m_epc        = 32'h0000_0000;
    m_aerr       = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] t;
    bit          redir;
    m_aerr = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (exc_req) begin
      m_epc        = m_pc;
      m_pc         = EXC_V;
      m_flush_left = FLUSH_N;
    end else if (fetch_ack && !stall) begin
      redir = 1'b1;
      if (eret)              t = m_epc;
      else if (jr)           t = jr_target;
      else if (jump)         t = jump_target;
      else if (branch_taken) t = branch_target;
      else begin
        redir = 1'b0;
        t = m_pc + 32'd4;
      end
      if (redir && (t % 4) != 0) begin
        m_epc        = m_pc;
        m_pc         = EXC_V;
        m_flush_left = FLUSH_N;
        m_aerr       = 1'b1;
      end else begin
        m_pc = t;
      end
    end
  endtask

  task automatic compare_model();
    check32("pc",        pc,        m_pc);
    check32("pc_plus4",  pc_plus4,  m_pc + 32'd4);
    check32("epc",       epc,       m_epc);
    check32("fetch_req", {31'd0, fetch_req}, {31'd0, (m_booted && m_flush_left == 0)});
    check32("in_flush",  {31'd0, in_flush},  {31'd0, (m_flush_left > 0)});
    check32("addr_err",  {31'd0, addr_err},  {31'd0, m_aerr});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic clear_inputs();
    stall = 1'b0; fetch_ack = 1'b0; exc_req = 1'b0; eret = 1'b0;
    jr = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jr_target = 32'h0; jump_target = 32'h0; branch_target = 32'h0;
  endtask

  // Asserts reset asynchronously, checks reset values, then releases it.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check32("rst_pc",        pc,                 32'h0000_0000);
    check32("rst_epc",       epc,                32'h0000_0000);
    check32("rst_fetch_req", {31'd0, fetch_req}, 32'd0);
    check32("rst_addr_err",  {31'd0, addr_err},  32'd0);
    check32("rst_in_flush",  {31'd0, in_flush},  32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check32("boot_fetch_req", {31'd0, fetch_req}, 32'd0);
  endtask

  typedef struct {
    bit          st, ak, ex, er, j_r, jm, br;
    logic [31:0] jrt, jmt, brt;
    logic [31:0] exp_pc;
    bit          exp_aerr, exp_flush;
  } vec_t;

  function automatic vec_t mk(input bit st, ak, ex, er, j_r, jm, br,
                              input logic [31:0] jrt, jmt, brt, exp_pc,
                              input bit exp_aerr, exp_flush);
    vec_t v;
    v.st = st; v.ak = ak; v.ex = ex; v.er = er; v.j_r = j_r; v.jm = jm; v.br = br;
    v.jrt = jrt; v.jmt = jmt; v.brt = brt;
    v.exp_pc = exp_pc; v.exp_aerr = exp_aerr; v.exp_flush = exp_flush;
    return v;
  endfunction

  vec_t tbl[24];

  initial begin
    clear_inputs();
    rst = 1'b1;
    #1;
    do_reset();
    fetch_ack = 1'b0;
    step();  // BOOT -> FETCH, fetch_req rises

`ifndef BRANCH_DELAY_SLOT_EN
    //          st ak ex er jr jm br   jr_t          jump_t        br_t          exp_pc        ae fl
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0004, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0008, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_000C, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 0, 0);
    tbl[4]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 0, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0010, 0, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0014, 0, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 1, 0, 32'h0,        32'h20,       32'h0,        32'h0000_0020, 0, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 1, 1, 32'h0,        32'h400,      32'h800,      32'h0000_0400, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h40,       32'h0000_0040, 0, 0);
    tbl[11] = mk(1, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        EXC_V,         0, 1);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        EXC_V,         0, 0);
    tbl[13] = mk(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0040, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 1, 0, 0, 32'h102,      32'h0,        32'h0,        EXC_V,         1, 1);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        EXC_V,         0, 0);
    tbl[16] = mk(0, 1, 0, 0, 0, 1, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'hFFFF_FFFC, 0, 0);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0000, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h300,      32'h0,        32'h0000_0000, 0, 0);
    tbl[19] = mk(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0000_0040, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h201,      EXC_V,         1, 1);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        EXC_V,         0, 0);
    tbl[22] = mk(0, 1, 0, 0, 1, 1, 0, 32'h500,      32'h600,      32'h0,        32'h0000_0500, 0, 0);
    tbl[23] = mk(0, 1, 0, 1, 1, 0, 0, 32'h900,      32'h0,        32'h0,        32'h0000_0040, 0, 0);

    for (int i = 0; i < 24; i++) begin
      stall = tbl[i].st; fetch_ack = tbl[i].ak; exc_req = tbl[i].ex; eret = tbl[i].er;
      jr = tbl[i].j_r; jump = tbl[i].jm; branch_taken = tbl[i].br;
      jr_target = tbl[i].jrt; jump_target = tbl[i].jmt; branch_target = tbl[i].brt;
      step();
      check32($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      check32($sformatf("tbl%0d_aerr", i), {31'd0, addr_err}, {31'd0, tbl[i].exp_aerr});
      check32($sformatf("tbl%0d_flush", i), {31'd0, in_flush}, {31'd0, tbl[i].exp_flush});
    end
    check32("tbl_epc_final", epc, 32'h0000_0040);

    // Randomized traffic with one asynchronous reset in the middle of fetching.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        clear_inputs();
        do_reset();
      end
      stall         = ($urandom_range(0, 3) == 0);
      fetch_ack     = ($urandom_range(0, 3) != 0);
      exc_req       = ($urandom_range(0, 29) == 0);
      eret          = ($urandom_range(0, 11) == 0);
      jr            = ($urandom_range(0, 9) == 0);
      jump          = ($urandom_range(0, 7) == 0);
      branch_taken  = ($urandom_range(0, 3) == 0);
      jr_target     = $urandom;
      jump_target   = $urandom;
      branch_target = $urandom;
      if ($urandom_range(0, 15) != 0) jr_target[1:0] = 2'b00;
      if ($urandom_range(0, 15) != 0) jump_target[1:0] = 2'b00;
      if ($urandom_range(0, 15) != 0) branch_target[1:0] = 2'b00;
      step();
    end
`else
    // Delayed branches: jump at 0x0 to 0x100, then branch at 0x100 to 0x200.
    fetch_ack = 1'b1; jump = 1'b1; jump_target = 32'h100;
    @(posedge clk); #1;
    check32("ds_slot0", pc, 32'h0000_0004);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
    @(posedge clk); #1;
    check32("ds_tgt0", pc, 32'h0000_0100);
    branch_target = 32'h200;
    @(posedge clk); #1;
    check32("ds_slot1", pc, 32'h0000_0104);
    branch_taken = 1'b0;
    @(posedge clk); #1;
    check32("ds_tgt1", pc, 32'h0000_0200);
    jump = 1'b1; jump_target = 32'h600;
    @(posedge clk); #1;
    check32("ds_slot2", pc, 32'h0000_0204);
    jump = 1'b0; fetch_ack = 1'b0; exc_req = 1'b1;
    @(posedge clk); #1;
    check32("ds_exc_pc", pc, EXC_V);
    check32("ds_exc_epc", epc, 32'h0000_0200);
    check32("ds_exc_flush", {31'd0, in_flush}, 32'd1);
    exc_req = 1'b0; fetch_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check32("ds_no_pending", pc, EXC_V + 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
